lsu: RTL and testbench
======================

Name: lsu

Overview:
- Load/store unit on the memory side of the single-cycle core.
- Consumes the datapath's ALUResult (address) and RegData2 (store data), and drives a valid/grant memory bus.
- Returns the extended load value on ReadData into the datapath's result path.
- Stalls the core (PC and register-file write) while a bus access is outstanding.

Parameters:
TIMEOUT, 16, max cycles spent in REQ or WAIT before the access is aborted with a timeout fault
CNT_W, 5, width of the timeout counter; must hold TIMEOUT

Ports:
clk  in  1  core clock, rising edge
reset  in  1  asynchronous, active-high
MemRead  in  1  current instruction is a load
MemWrite  in  1  current instruction is a store
Funct3  in  3  instr[14:12]: size and sign of the access
Addr  in  32  byte address (datapath ALUResult)
StoreData  in  32  store data (datapath RegData2)
ReadData  out  32  extended load result; valid in DONE
Stall  out  1  hold PC and block RegWrite
Fault  out  1  access failed; valid in DONE only
FaultCause  out  2  01 misaligned, 10 timeout, 11 illegal (bad Funct3 or MemRead&MemWrite)
mem_req  out  1  bus request
mem_we  out  1  1 = write
mem_addr  out  32  word-aligned address, {Addr[31:2],2'b00}
mem_be  out  4  byte enables
mem_wdata  out  32  lane-replicated store data
mem_gnt  in  1  request accepted this cycle
mem_rvalid  in  1  read data valid this cycle
mem_rdata  in  32  read data word

Behaviour:
- Reset:
  - state IDLE.
  - All outputs 0, including ReadData, Fault, FaultCause, mem_*.
  - Reset mid-transaction aborts immediately: mem_req drops asynchronously, no fault is raised, and the bus transaction is abandoned.
- States:
  - IDLE:
    - Access starts when MemRead|MemWrite.
    - Check legality:
      - Loads: Funct3 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu.
      - Stores: 000 sb, 001 sh, 010 sw.
      - Alignment: half needs Addr[0]=0; word needs Addr[1:0]=0.
    - Illegal or misaligned: go to DONE with the fault latched; no bus activity.
    - Legal: register Addr, StoreData, Funct3 and direction; go to REQ.
  - REQ:
    - mem_req=1.
    - mem_we, mem_addr, mem_be and mem_wdata come from the registered copies and are held stable until mem_gnt.
    - On mem_gnt:
      - Write: go to DONE.
      - Read: go to WAIT. If mem_rvalid is also high in that cycle, capture the data and go straight to DONE.
  - WAIT:
    - mem_req=0.
    - On mem_rvalid: capture the extended mem_rdata into ReadData; go to DONE.
  - DONE:
    - Stall=0, ReadData/Fault/FaultCause valid for exactly this cycle.
    - Inputs are ignored.
    - Next state is always IDLE.
- Stall (combinational):
  - 1 in IDLE when an access starts (legal or not).
  - 1 in REQ and WAIT.
  - 0 otherwise.
- Timeout:
  - The counter clears on entry to REQ and WAIT and increments each cycle in those states.
  - Reaching TIMEOUT: go to DONE with Fault=1, cause 10, ReadData=0, mem_req dropped.
- Byte lanes:
  - sb: mem_be = 4'b0001 << Addr[1:0], mem_wdata = {4{StoreData[7:0]}}.
  - sh: mem_be = Addr[1] ? 4'b1100 : 4'b0011, mem_wdata = {2{StoreData[15:0]}}.
  - sw: mem_be = 4'b1111, mem_wdata = StoreData.
  - Reads drive mem_be = 4'b1111.
- Load extraction:
  - Select the byte or half by registered Addr[1:0].
  - lb/lh sign-extend; lbu/lhu zero-extend; lw passes the word.
- ReadData is 0 in DONE after any write or fault.
- Latency:
  - Store with immediate grant: 2 stall cycles.
  - Load with grant then rvalid one cycle later: 3 stall cycles.
  - Fault without bus activity: 1 stall cycle.
- Stray mem_gnt or mem_rvalid in IDLE/DONE, or mem_gnt in WAIT, is ignored.

Decomposition:
- lsu_pkg holds:
  - lsu_state_t enum (IDLE, REQ, WAIT, DONE).
  - Funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - fault_cause_t enum (NONE, MISALIGN, TIMEOUT, ILLEGAL).
- One combinational sub-module, lsu_align, handles:
  - store lane steering (mem_be, mem_wdata);
  - load extraction/extension;
  - the legality and alignment check.
- lsu keeps the FSM, the registered copies and the timeout counter.

Test Plan:
- sw Addr=0x100 StoreData=0xDEADBEEF, mem_gnt in the first REQ cycle -> mem_be=1111, mem_addr=0x100, Stall high 2 cycles, DONE with Fault=0.
- sb Addr=0x103 StoreData=0x000000A5 -> mem_be=1000, mem_wdata=0xA5A5A5A5, mem_addr=0x100.
- lb Addr=0x102 with mem_rdata=0x12F45678 -> ReadData=0xFFFFFFF4; repeated as lbu -> 0x000000F4; lhu Addr=0x102 -> 0x000012F4.
- lw Addr=0x101 -> no mem_req, 1 stall cycle, DONE with Fault=1, FaultCause=01; Funct3=011 load -> FaultCause=11.
- Load with mem_gnt and no mem_rvalid for 16 WAIT cycles -> Fault=1, FaultCause=10, ReadData=0, return to IDLE.
- Reset asserted in WAIT -> mem_req=0, Stall=0, ReadData=0 immediately; a later mem_rvalid is ignored and the next lw completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: FSM states, access sizes and fault causes.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_state_t;

    typedef enum logic [1:0] {
        NONE     = 2'b00,
        MISALIGN = 2'b01,
        TIMEOUT  = 2'b10,
        ILLEGAL  = 2'b11
    } fault_cause_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: access legality check, store byte-lane steering, load extraction.
// Zero latency; no flow control of its own.
module lsu_align
    import lsu_pkg::*;
(
    input  logic         chk_rd,
    input  logic         chk_wr,
    input  logic [2:0]   chk_f3,
    input  logic [1:0]   chk_lo,
    output fault_cause_t chk_cause,
    input  logic         acc_we,
    input  logic [2:0]   acc_f3,
    input  logic [1:0]   acc_lo,
    input  logic [31:0]  acc_sdata,
    input  logic [31:0]  acc_rdata,
    output logic [3:0]   acc_be,
    output logic [31:0]  acc_wdata,
    output logic [31:0]  acc_load
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Both directions asserted at once is treated as a malformed instruction.
    always_comb begin
        chk_cause = NONE;
        if (chk_rd && chk_wr) begin
            chk_cause = ILLEGAL;
        end else if (chk_rd || chk_wr) begin
            case (chk_f3)
                F3_B:    chk_cause = NONE;
                F3_H:    chk_cause = chk_lo[0] ? MISALIGN : NONE;
                F3_W:    chk_cause = (chk_lo != 2'b00) ? MISALIGN : NONE;
                F3_BU:   chk_cause = chk_wr ? ILLEGAL : NONE;
                F3_HU:   chk_cause = chk_wr ? ILLEGAL : (chk_lo[0] ? MISALIGN : NONE);
                default: chk_cause = ILLEGAL;
            endcase
        end
    end

    always_comb begin
        acc_be    = 4'b1111;
        acc_wdata = acc_sdata;
        if (acc_we) begin
            case (acc_f3)
                F3_B: begin
                    acc_be    = 4'b0001 << acc_lo;
                    acc_wdata = {4{acc_sdata[7:0]}};
                end
                F3_H: begin
                    acc_be    = acc_lo[1] ? 4'b1100 : 4'b0011;
                    acc_wdata = {2{acc_sdata[15:0]}};
                end
                default: begin
                    acc_be    = 4'b1111;
                    acc_wdata = acc_sdata;
                end
            endcase
        end
    end

    always_comb begin
        case (acc_lo)
            2'd0:    byte_sel = acc_rdata[7:0];
            2'd1:    byte_sel = acc_rdata[15:8];
            2'd2:    byte_sel = acc_rdata[23:16];
            default: byte_sel = acc_rdata[31:24];
        endcase
        half_sel = acc_lo[1] ? acc_rdata[31:16] : acc_rdata[15:0];
        case (acc_f3)
            F3_B:    acc_load = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   acc_load = {24'd0, byte_sel};
            F3_H:    acc_load = {{16{half_sel[15]}}, half_sel};
            F3_HU:   acc_load = {16'd0, half_sel};
            default: acc_load = acc_rdata;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit between the single-cycle core and a valid/grant memory bus.
// Stalls the core from access start until DONE; faults skip the bus entirely.
module lsu
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  Funct3,
    input  logic [31:0] Addr,
    input  logic [31:0] StoreData,
    output logic [31:0] ReadData,
    output logic        Stall,
    output logic        Fault,
    output logic [1:0]  FaultCause,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    lsu_state_t   state_q, state_d;
    logic [31:0]  addr_q, addr_d;
    logic [31:0]  sdata_q, sdata_d;
    logic [2:0]   f3_q, f3_d;
    logic         we_q, we_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]  rdata_q, rdata_d;
    logic         fault_q, fault_d;
    fault_cause_t cause_q, cause_d;
    logic         stall_c;

    fault_cause_t chk_cause;
    logic [3:0]   be_w;
    logic [31:0]  wdata_w;
    logic [31:0]  load_w;

    lsu_align u_align (
        .chk_rd    (MemRead),
        .chk_wr    (MemWrite),
        .chk_f3    (Funct3),
        .chk_lo    (Addr[1:0]),
        .chk_cause (chk_cause),
        .acc_we    (we_q),
        .acc_f3    (f3_q),
        .acc_lo    (addr_q[1:0]),
        .acc_sdata (sdata_q),
        .acc_rdata (mem_rdata),
        .acc_be    (be_w),
        .acc_wdata (wdata_w),
        .acc_load  (load_w)
    );

    // Result registers default to zero so they only carry data during DONE.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        sdata_d = sdata_q;
        f3_d    = f3_q;
        we_d    = we_q;
        cnt_d   = cnt_q;
        rdata_d = '0;
        fault_d = 1'b0;
        cause_d = NONE;
        stall_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (MemRead || MemWrite) begin
                    stall_c = 1'b1;
                    if (chk_cause != NONE) begin
                        state_d = DONE;
                        fault_d = 1'b1;
                        cause_d = chk_cause;
                    end else begin
                        state_d = REQ;
                        addr_d  = Addr;
                        sdata_d = StoreData;
                        f3_d    = Funct3;
                        we_d    = MemWrite;
                        cnt_d   = '0;
                    end
                end
            end
            REQ: begin
                stall_c = 1'b1;
                if (mem_gnt) begin
                    if (we_q) begin
                        state_d = DONE;
                    end else if (mem_rvalid) begin
                        state_d = DONE;
                        rdata_d = load_w;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = '0;
                    end
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d = DONE;
                    fault_d = 1'b1;
                    cause_d = lsu_pkg::TIMEOUT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT: begin
                stall_c = 1'b1;
                if (mem_rvalid) begin
                    state_d = DONE;
                    rdata_d = load_w;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d = DONE;
                    fault_d = 1'b1;
                    cause_d = lsu_pkg::TIMEOUT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            sdata_q <= '0;
            f3_q    <= '0;
            we_q    <= 1'b0;
            cnt_q   <= '0;
            rdata_q <= '0;
            fault_q <= 1'b0;
            cause_q <= NONE;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            sdata_q <= sdata_d;
            f3_q    <= f3_d;
            we_q    <= we_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            fault_q <= fault_d;
            cause_q <= cause_d;
        end
    end

    // Bus fields are forced to zero outside REQ so an idle bus carries nothing.
    assign mem_req    = (state_q == REQ);
    assign mem_we     = mem_req & we_q;
    assign mem_addr   = mem_req ? {addr_q[31:2], 2'b00} : 32'd0;
    assign mem_be     = mem_req ? be_w : 4'd0;
    assign mem_wdata  = mem_we ? wdata_w : 32'd0;
    assign Stall      = stall_c & ~reset;
    assign ReadData   = rdata_q;
    assign Fault      = fault_q;
    assign FaultCause = cause_q;

endmodule

// File: tb/tb_lsu.sv
// Randomized bench for lsu with a transaction-level reference model and directed literal checks.
module tb_lsu;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemRead, MemWrite;
    logic [2:0]  Funct3;
    logic [31:0] Addr, StoreData;
    logic [31:0] ReadData;
    logic        Stall, Fault;
    logic [1:0]  FaultCause;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    lsu #(.TIMEOUT(TO), .CNT_W(5)) dut (
        .clk        (clk),
        .reset      (reset),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .Funct3     (Funct3),
        .Addr       (Addr),
        .StoreData  (StoreData),
        .ReadData   (ReadData),
        .Stall      (Stall),
        .Fault      (Fault),
        .FaultCause (FaultCause),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Per-cycle expectations, set by the transaction driver.
    bit          e_stall, e_req, e_we, e_done, e_fault;
    logic [31:0] e_addr, e_wdata, e_rd;
    logic [3:0]  e_be;
    logic [1:0]  e_cause;

    int          obs_stall;
    logic [3:0]  last_be;
    logic [31:0] last_addr, last_wdata, last_rd;
    logic        last_fault;
    logic [1:0]  last_cause;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cmp();
        #2;
        chk("stall", Stall, e_stall);
        if (Stall) obs_stall++;
        chk("mem_req", mem_req, e_req);
        if (e_req) begin
            chk("mem_we", mem_we, e_we);
            chk("mem_addr", mem_addr, e_addr);
            chk("mem_be", mem_be, e_be);
            if (e_we) chk("mem_wdata", mem_wdata, e_wdata);
            last_be    = mem_be;
            last_addr  = mem_addr;
            last_wdata = mem_wdata;
        end
        if (e_done) begin
            chk("fault", Fault, e_fault);
            chk("fault_cause", FaultCause, e_cause);
            chk("read_data", ReadData, e_rd);
            last_rd    = ReadData;
            last_fault = Fault;
            last_cause = FaultCause;
        end
    endtask

    function automatic logic [1:0] m_cause(bit rd, bit wr, logic [2:0] f3, logic [31:0] a);
        int sz;
        if (rd && wr) return 2'b11;
        sz = -1;
        if (rd) begin
            if (f3 == 3'd0 || f3 == 3'd4) sz = 0;
            else if (f3 == 3'd1 || f3 == 3'd5) sz = 1;
            else if (f3 == 3'd2) sz = 2;
        end else begin
            if (f3 == 3'd0) sz = 0;
            else if (f3 == 3'd1) sz = 1;
            else if (f3 == 3'd2) sz = 2;
        end
        if (sz < 0) return 2'b11;
        if ((a % (32'd1 << sz)) != 0) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [3:0] m_be(bit wr, logic [2:0] f3, logic [31:0] a);
        if (!wr || f3 == 3'd2) return 4'hF;
        if (f3 == 3'd0) return 4'(1 << (a % 4));
        return ((a % 4) >= 2) ? 4'hC : 4'h3;
    endfunction

    function automatic logic [31:0] m_wdata(logic [2:0] f3, logic [31:0] sd);
        if (f3 == 3'd0) return (sd & 32'hFF) * 32'h0101_0101;
        if (f3 == 3'd1) return (sd & 32'hFFFF) * 32'h0001_0001;
        return sd;
    endfunction

    function automatic logic [31:0] m_load(logic [2:0] f3, logic [31:0] a, logic [31:0] w);
        logic [31:0] t;
        if (f3 == 3'd0 || f3 == 3'd4) begin
            t = (w >> (8 * (a % 4))) & 32'hFF;
            if (f3 == 3'd0 && t >= 32'h80) t = t | 32'hFFFF_FF00;
        end else if (f3 == 3'd1 || f3 == 3'd5) begin
            t = (w >> (16 * ((a % 4) / 2))) & 32'hFFFF;
            if (f3 == 3'd1 && t >= 32'h8000) t = t | 32'hFFFF_0000;
        end else begin
            t = w;
        end
        return t;
    endfunction

    // gd: REQ cycles before grant; rv: cycles after the grant cycle until rvalid (0 = same cycle).
    task automatic run_txn(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] sd, input int gd, input int rv, input logic [31:0] rw);
        logic [1:0] c;
        int k;
        bit to;
        c  = m_cause(rd, wr, f3, a);
        to = 0;
        @(negedge clk);
        MemRead = rd; MemWrite = wr; Funct3 = f3; Addr = a; StoreData = sd;
        mem_gnt = 1'($urandom_range(0, 1)); mem_rvalid = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
        e_stall = 1; e_req = 0; e_done = 0;
        cmp();
        if (c == 2'b00) begin
            e_we = wr; e_addr = a & 32'hFFFF_FFFC; e_be = m_be(wr, f3, a); e_wdata = m_wdata(f3, sd);
            k = 0;
            while (1) begin
                @(negedge clk);
                mem_gnt = (k == gd);
                mem_rvalid = mem_gnt && !wr && (rv == 0);
                mem_rdata = rw;
                e_stall = 1; e_req = 1;
                cmp();
                k++;
                if (mem_gnt) break;
                if (k == TO) begin to = 1; break; end
            end
            if (!to && !wr && rv != 0) begin
                k = 0;
                while (1) begin
                    @(negedge clk);
                    k++;
                    mem_gnt = 1'($urandom_range(0, 1));
                    mem_rvalid = (k == rv);
                    mem_rdata = mem_rvalid ? rw : $urandom;
                    e_stall = 1; e_req = 0;
                    cmp();
                    if (mem_rvalid) break;
                    if (k == TO) begin to = 1; break; end
                end
            end
        end
        @(negedge clk);
        MemRead = 1'($urandom_range(0, 1)); MemWrite = 1'($urandom_range(0, 1));
        Funct3 = 3'($urandom); Addr = $urandom;
        mem_gnt = 1'($urandom_range(0, 1)); mem_rvalid = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
        e_stall = 0; e_req = 0; e_done = 1;
        if (c != 2'b00) begin
            e_fault = 1; e_cause = c; e_rd = 0;
        end else if (to) begin
            e_fault = 1; e_cause = 2'b10; e_rd = 0;
        end else begin
            e_fault = 0; e_cause = 2'b00; e_rd = wr ? 32'd0 : m_load(f3, a, rw);
        end
        cmp();
        e_done = 0;
        @(negedge clk);
        MemRead = 0; MemWrite = 0;
        mem_gnt = 1'($urandom_range(0, 1)); mem_rvalid = 1'($urandom_range(0, 1));
        e_stall = 0; e_req = 0;
        cmp();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit rd, wr;
        logic [2:0]  f3;
        logic [31:0] a;
        int gd, rv;

        reset = 1; MemRead = 0; MemWrite = 0; Funct3 = 0; Addr = 0; StoreData = 0;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
        e_stall = 0; e_req = 0; e_we = 0; e_done = 0; e_fault = 0;
        e_addr = 0; e_wdata = 0; e_rd = 0; e_be = 0; e_cause = 0;
        #12;
        chk("rst_read_data", ReadData, 32'd0);
        chk("rst_stall", Stall, 32'd0);
        chk("rst_fault", {Fault, FaultCause}, 32'd0);
        chk("rst_mem_ctl", {mem_req, mem_we, mem_be}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        @(negedge clk);
        reset = 0;

        obs_stall = 0;
        run_txn(0, 1, 3'd2, 32'h100, 32'hDEAD_BEEF, 0, 0, 32'd0);
        chk("sw_be", last_be, 32'hF);
        chk("sw_addr", last_addr, 32'h100);
        chk("sw_wdata", last_wdata, 32'hDEAD_BEEF);
        chk("sw_stall_cycles", obs_stall, 32'd2);
        chk("sw_fault", last_fault, 32'd0);

        run_txn(0, 1, 3'd0, 32'h103, 32'h0000_00A5, 0, 0, 32'd0);
        chk("sb_be", last_be, 32'h8);
        chk("sb_wdata", last_wdata, 32'hA5A5_A5A5);
        chk("sb_addr", last_addr, 32'h100);

        obs_stall = 0;
        run_txn(1, 0, 3'd0, 32'h102, 32'd0, 0, 1, 32'h12F4_5678);
        chk("lb_data", last_rd, 32'hFFFF_FFF4);
        chk("lb_stall_cycles", obs_stall, 32'd3);
        run_txn(1, 0, 3'd4, 32'h102, 32'd0, 0, 1, 32'h12F4_5678);
        chk("lbu_data", last_rd, 32'h0000_00F4);
        run_txn(1, 0, 3'd5, 32'h102, 32'd0, 0, 1, 32'h12F4_5678);
        chk("lhu_data", last_rd, 32'h0000_12F4);

        obs_stall = 0;
        run_txn(1, 0, 3'd2, 32'h101, 32'd0, 0, 1, 32'd0);
        chk("lw_mis_stall_cycles", obs_stall, 32'd1);
        chk("lw_mis_fault", last_fault, 32'd1);
        chk("lw_mis_cause", last_cause, 32'd1);
        run_txn(1, 0, 3'd3, 32'h100, 32'd0, 0, 1, 32'd0);
        chk("ld_f3_011_cause", last_cause, 32'd3);

        run_txn(1, 0, 3'd2, 32'h100, 32'd0, 0, 100, 32'h1234_5678);
        chk("wait_to_fault", last_fault, 32'd1);
        chk("wait_to_cause", last_cause, 32'd2);
        chk("wait_to_data", last_rd, 32'd0);
        run_txn(0, 1, 3'd2, 32'h100, 32'h1, 100, 0, 32'd0);
        chk("req_to_cause", last_cause, 32'd2);

        // Reset while waiting for read data.
        @(negedge clk);
        MemRead = 1; MemWrite = 0; Funct3 = 3'd2; Addr = 32'h200; mem_gnt = 0; mem_rvalid = 0;
        e_stall = 1; e_req = 0; e_done = 0;
        cmp();
        @(negedge clk);
        mem_gnt = 1; e_req = 1; e_we = 0; e_addr = 32'h200; e_be = 4'hF;
        cmp();
        @(negedge clk);
        mem_gnt = 0; e_req = 0;
        cmp();
        #1 reset = 1;
        #1;
        chk("rst_wait_mem_req", mem_req, 32'd0);
        chk("rst_wait_stall", Stall, 32'd0);
        chk("rst_wait_read_data", ReadData, 32'd0);
        @(negedge clk);
        reset = 0; MemRead = 0; mem_rvalid = 1; mem_rdata = 32'h5555_AAAA;
        e_stall = 0; e_req = 0;
        cmp();
        @(negedge clk);
        mem_rvalid = 0;
        cmp();
        chk("stray_rvalid_read_data", ReadData, 32'd0);
        chk("stray_rvalid_fault", Fault, 32'd0);
        run_txn(1, 0, 3'd2, 32'h204, 32'd0, 0, 1, 32'hCAFE_F00D);
        chk("post_rst_lw_data", last_rd, 32'hCAFE_F00D);

        for (int i = 0; i < 200; i++) begin
            int op;
            op = $urandom_range(0, 9);
            rd = (op <= 4) || (op == 9);
            wr = (op >= 5);
            if ($urandom_range(0, 4) == 0) begin
                f3 = 3'($urandom);
            end else begin
                f3 = 3'($urandom_range(0, 2));
                if (rd && f3 != 3'd2 && $urandom_range(0, 1) == 1) f3 = f3 + 3'd4;
            end
            a = $urandom;
            if ($urandom_range(0, 2) != 0) a = a & 32'hFFFF_FFFC;
            gd = ($urandom_range(0, 15) == 0) ? 20 : $urandom_range(0, 3);
            rv = ($urandom_range(0, 15) == 0) ? 30 : $urandom_range(0, 4);
            run_txn(rd, wr, f3, a, $urandom, gd, rv, $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
